pipe_ctrl: RTL

Central pipeline controller for the 5-stage MIPS core. It merges stall requests from the ID, EX and MEM stages into one stall vector that drives the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It sequences exception entry and ERET return as a freeze-then-flush cycle pair and supplies the redirect PC. It also runs a MEM bus-wait watchdog that raises a bus-error exception when a memory access never completes.

---
 rtl/cpu_defs_pkg.sv | 50 +++++
 rtl/bus_watchdog.sv | 31 +++
 rtl/pipe_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared pipeline-control definitions: stall encodings, exception types/codes, controller states.
package cpu_defs_pkg;

    // Stall vector bit positions; a 1 holds the corresponding stage register.
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_ID_REQ  = 6'b000111;
    localparam logic [5:0] STALL_EX_REQ  = 6'b001111;
    localparam logic [5:0] STALL_MEM_REQ = 6'b011111;
    localparam logic [5:0] STALL_ALL     = 6'b111111;

    localparam logic [31:0] EXCTYPE_INT  = 32'h1;
    localparam logic [31:0] EXCTYPE_SYS  = 32'h8;
    localparam logic [31:0] EXCTYPE_RI   = 32'hA;
    localparam logic [31:0] EXCTYPE_OV   = 32'hC;
    localparam logic [31:0] EXCTYPE_TR   = 32'hD;
    localparam logic [31:0] EXCTYPE_ERET = 32'hE;

    localparam logic [4:0] EXCCODE_INT = 5'd0;
    localparam logic [4:0] EXCCODE_DBE = 5'd7;
    localparam logic [4:0] EXCCODE_SYS = 5'd8;
    localparam logic [4:0] EXCCODE_RI  = 5'd10;
    localparam logic [4:0] EXCCODE_OV  = 5'd12;
    localparam logic [4:0] EXCCODE_TR  = 5'd13;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_e;

    // Unknown nonzero types are reported as reserved-instruction.
    function automatic logic [4:0] exc_code_of(input logic [31:0] exc_type);
        case (exc_type)
            EXCTYPE_INT:  exc_code_of = EXCCODE_INT;
            EXCTYPE_SYS:  exc_code_of = EXCCODE_SYS;
            EXCTYPE_RI:   exc_code_of = EXCCODE_RI;
            EXCTYPE_OV:   exc_code_of = EXCCODE_OV;
            EXCTYPE_TR:   exc_code_of = EXCCODE_TR;
            EXCTYPE_ERET: exc_code_of = EXCCODE_INT;
            default:      exc_code_of = EXCCODE_RI;
        endcase
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts consecutive MEM bus-wait cycles; strobes timeout_hit_o on the last allowed cycle.
// Counter saturates instead of wrapping; clr_i forces it back to zero.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic timeout_hit_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX  = '1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (cnt_q != MAX) cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout_hit_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences exception/ERET freeze-then-flush.
// Flush follows detection by one cycle; stall vector is combinational.
module pipe_ctrl
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [4:0]  exc_code_o,
    output logic        bus_timeout
);

    ctrl_state_e state_q;
    logic        flush_q;
    logic [31:0] new_pc_q;
    logic [4:0]  exc_code_q;
    logic        bus_timeout_q;

    logic run;
    logic sw_exc;
    logic wd_hit;
    logic exc_hit;

    assign run     = (state_q == ST_RUN);
    assign sw_exc  = (excepttype_i != 32'h0);
    assign exc_hit = run && (sw_exc || wd_hit);

    // Watchdog is held at zero for the whole redirect so a still-pending access restarts from 0.
    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wd (
        .clk          (clk),
        .rst          (rst),
        .en_i         (stallreq_mem),
        .clr_i        (exc_hit || !run),
        .timeout_hit_o(wd_hit)
    );

    always_comb begin
        stall = STALL_NONE;
        if (rst || !run)       stall = STALL_NONE;
        else if (exc_hit)      stall = STALL_ALL;
        else if (stallreq_mem) stall = STALL_MEM_REQ;
        else if (stallreq_ex)  stall = STALL_EX_REQ;
        else if (stallreq_id)  stall = STALL_ID_REQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'h0;
            exc_code_q    <= 5'd0;
            bus_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    flush_q       <= 1'b0;
                    bus_timeout_q <= 1'b0;
                    if (exc_hit) begin
                        state_q       <= ST_FLUSH;
                        flush_q       <= 1'b1;
                        new_pc_q      <= (excepttype_i == EXCTYPE_ERET) ? cp0_epc_i : EXC_VECTOR;
                        // A software exception in the same cycle outranks the watchdog.
                        exc_code_q    <= sw_exc ? exc_code_of(excepttype_i) : EXCCODE_DBE;
                        bus_timeout_q <= !sw_exc;
                    end
                end
                default: begin
                    state_q       <= ST_RUN;
                    flush_q       <= 1'b0;
                    bus_timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush       = flush_q;
    assign new_pc      = new_pc_q;
    assign exc_code_o  = exc_code_q;
    assign bus_timeout = bus_timeout_q;

endmodule
